vec_mul_pipe: RTL and testbench
===============================

# vec_mul_pipe

Parametrised, pipelined vector integer multiplier for the RISC-V vector execute stage. It multiplies two VLEN-bit vector operands element-wise at a runtime-selected element width (8/16/32/64-bit). It returns either the low or the high half of each 2·SEW-bit product, with signed, unsigned and mixed-sign variants (vmul, vmulh, vmulhu, vmulhsu). A valid/ready handshake on both sides gives full throughput, backpressure and per-operation tag passthrough. It replaces the fixed 256-bit, low-half-only, combinational multiplier.

## Interface
- VLEN, 256: vector operand width in bits; must be a multiple of 64.
- STAGES, 3: pipeline depth in cycles, ≥1. Stage 1 computes the products; stages 2..STAGES are register stages available to DSP retiming.
- TAG_W, 8: width of the sideband tag carried alongside each operation.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- valid_i  in  1  input operation valid.
- ready_o  out  1  block can accept an operation this cycle.
- a_i  in  VLEN  operand vs2.
- b_i  in  VLEN  operand vs1.
- sew_i  in  3  element width: 000 = 8, 001 = 16, 010 = 32, 011 = 64; 1xx is illegal.
- op_i  in  2  operation select:
  - 00 = vmul: low half of the product.
  - 01 = vmulh: signed×signed, high half.
  - 10 = vmulhu: unsigned×unsigned, high half.
  - 11 = vmulhsu: a signed × b unsigned, high half.
- tag_i  in  TAG_W  sideband tag, returned unchanged with the result.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- res_o  out  VLEN  element-wise result.
- tag_o  out  TAG_W  tag of the result currently presented.
- err_o  out  1  qualified by valid_o; set when the operation was issued with an illegal sew_i.

## Operation
- Element count per operation: N = VLEN/SEW. Element k occupies bits [k·SEW+SEW-1 : k·SEW] of a_i, b_i and res_o.
- Operand extension, per element, to 2·SEW bits:
  - a is sign-extended for op 01 and 11, otherwise zero-extended.
  - b is sign-extended for op 01 only.
- Full product P = ext(a) × ext(b), truncated to 2·SEW bits.
- Result selection: op 00 returns P[SEW-1:0]; all other ops return P[2·SEW-1:SEW].
- vmul low half is sign-agnostic. The same a/b gives the same result for all signedness interpretations.
- Illegal sew_i (1xx): the operation is accepted and flows through the pipeline normally, with res_o = 0 and err_o = 1.
- Every stage holds a valid bit plus payload (result or partial products, tag, err).
- Stage advance rules:
  - Last stage advances when ready_i = 1 or its valid bit is 0.
  - Stage s advances when stage s+1 advances or stage s+1 is empty.
  - ready_o = stage 1 empty or stage 1 advancing. ready_o depends combinationally on ready_i, which is needed for back-to-back throughput.
- Transfer rules:
  - Input transfer occurs when valid_i & ready_o; operands, sew_i, op_i and tag_i are captured on that edge.
  - Output transfer occurs when valid_o & ready_i.
- While a stage is stalled, its payload is held unchanged. res_o and tag_o stay stable while valid_o = 1 and ready_i = 0.
- Operations are never reordered, dropped or duplicated.

## Timing
- Latency: an operation accepted at edge t presents valid_o = 1 after edge t+STAGES-1, provided there is no backpressure. With STAGES = 1, the result is registered once and is visible the cycle after acceptance.
- Throughput: 1 operation per cycle while ready_i = 1.
- Capacity: STAGES operations in flight. With ready_i held low, ready_o drops after STAGES accepts.
- Simultaneous accept and emit while full: allowed in the same cycle, with no bubble.
- Reset (asynchronous assert; deassert synchronised externally):
  - All stage valid bits are cleared, so valid_o = 0 and err_o = 0.
  - res_o = 0 and tag_o = 0.
  - ready_o = 1 on the first cycle after reset.
- Reset mid-operation: all in-flight operations are discarded and no partial result appears.
- valid_o = 0: res_o and tag_o keep their last values (0 after reset) and are don't-care to the consumer.
- Changing sew_i or op_i between consecutive operations needs no idle cycle.

## Test plan
- 8-bit vmul: a = 0x..FF per byte, b = 0x..02 per byte, VLEN = 256 -> every byte of res_o = 0xFE, err_o = 0, valid_o rises exactly STAGES-1 cycles after the accept edge.
- 16-bit high variants: a element = 0xFFFF, b element = 0xFFFF.
  - vmulh -> 0x0000.
  - vmulhu -> 0xFFFE.
  - vmulhsu -> 0xFFFF.
  - vmul -> 0x0001.
- 64-bit vmulhu: a = b = 0xFFFFFFFFFFFFFFFF per element -> high = 0xFFFFFFFFFFFFFFFE; vmul on the same operands -> 0x0000000000000001 in all 4 elements.
- Backpressure:
  - Stimulus: stream 10 ops with tags 0..9 and ready_i low for 5 cycles mid-stream.
  - Required: valid_o is held with a stable payload, ready_o = 0 once STAGES ops are buffered, and all 10 tags emerge in order with correct results.
- Illegal sew_i = 100 with tag 0x5A -> res_o = 0, err_o = 1, tag_o = 0x5A; the following legal op returns err_o = 0.
- Assert rst_ni with 3 ops in flight -> valid_o falls immediately and none of those tags ever appears; ready_o = 1 after release.

Source files
------------

// File: rtl/vec_mul_pipe.sv
// vec_mul_pipe: element-wise vector integer multiplier (SEW 8/16/32/64),
// low/high product select, valid/ready pipeline with tag passthrough.
module vec_mul_pipe #(
    parameter int VLEN   = 256,
    parameter int STAGES = 3,
    parameter int TAG_W  = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [VLEN-1:0]  a_i,
    input  logic [VLEN-1:0]  b_i,
    input  logic [2:0]       sew_i,
    input  logic [1:0]       op_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [VLEN-1:0]  res_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             err_o
);

    typedef struct packed {
        logic [VLEN-1:0]  res;
        logic [TAG_W-1:0] tag;
        logic             err;
    } stage_t;

    logic mul_lo;
    logic a_sgn;
    logic b_sgn;

    assign mul_lo = (op_i == 2'b00);
    assign a_sgn  = op_i[0];
    assign b_sgn  = (op_i == 2'b01);

    // One multiplier array per element width; the SEW mux picks one.
    for (genvar w = 0; w < 4; w++) begin : g_w
        localparam int SEW = 8 << w;
        logic [VLEN-1:0] r;
        for (genvar k = 0; k < VLEN / SEW; k++) begin : g_e
            logic [SEW-1:0]   ea;
            logic [SEW-1:0]   eb;
            logic [2*SEW-1:0] xa;
            logic [2*SEW-1:0] xb;
            logic [2*SEW-1:0] p;
            assign ea = a_i[k*SEW +: SEW];
            assign eb = b_i[k*SEW +: SEW];
            assign xa = {{SEW{a_sgn & ea[SEW-1]}}, ea};
            assign xb = {{SEW{b_sgn & eb[SEW-1]}}, eb};
            assign p  = xa * xb;
            assign r[k*SEW +: SEW] = mul_lo ? p[SEW-1:0] : p[2*SEW-1:SEW];
        end
    end

    stage_t in_d;

    always_comb begin
        in_d.tag = tag_i;
        in_d.err = 1'b0;
        in_d.res = '0;
        case (sew_i)
            3'b000:  in_d.res = g_w[0].r;
            3'b001:  in_d.res = g_w[1].r;
            3'b010:  in_d.res = g_w[2].r;
            3'b011:  in_d.res = g_w[3].r;
            default: in_d.err = 1'b1;
        endcase
    end

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] cap;
    logic [STAGES-1:0] in_v;
    stage_t            pipe [STAGES];
    stage_t            in_p [STAGES];

    // cap[s]: stage s takes new content this edge (empty or moving on).
    always_comb begin
        logic acc;
        cap = '0;
        acc = ready_i;
        for (int s = STAGES - 1; s >= 0; s--) begin
            acc    = acc | ~vld[s];
            cap[s] = acc;
        end
    end

    always_comb begin
        in_v    = '0;
        in_v[0] = valid_i;
        in_p[0] = in_d;
        for (int s = 1; s < STAGES; s++) begin
            in_v[s] = vld[s-1];
            in_p[s] = pipe[s-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld <= '0;
            for (int s = 0; s < STAGES; s++) begin
                pipe[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (cap[s]) begin
                    vld[s] <= in_v[s];
                    if (in_v[s]) begin
                        pipe[s] <= in_p[s];
                    end
                end
            end
        end
    end

    assign ready_o = cap[0];
    assign valid_o = vld[STAGES-1];
    assign res_o   = pipe[STAGES-1].res;
    assign tag_o   = pipe[STAGES-1].tag;
    assign err_o   = vld[STAGES-1] & pipe[STAGES-1].err;

endmodule

// File: tb/tb_vec_mul_pipe.sv
// Scoreboard bench for vec_mul_pipe: directed vectors, queued expectations,
// independent output monitor.
module tb_vec_mul_pipe;

    localparam int V  = 256;
    localparam int S  = 3;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [V-1:0]  a_i = '0;
    logic [V-1:0]  b_i = '0;
    logic [2:0]    sew_i = '0;
    logic [1:0]    op_i = '0;
    logic [TW-1:0] tag_i = '0;
    logic          valid_o;
    logic          ready_i = 1'b1;
    logic [V-1:0]  res_o;
    logic [TW-1:0] tag_o;
    logic          err_o;

    vec_mul_pipe #(.VLEN(V), .STAGES(S), .TAG_W(TW)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .sew_i(sew_i), .op_i(op_i), .tag_i(tag_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .res_o(res_o), .tag_o(tag_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [V-1:0]  res;
        logic [TW-1:0] tag;
        logic          err;
        bit            lat;
        int            acc;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [V-1:0] act,
                         input logic [V-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // Entered and left on a negedge; pushes the expectation after the accept edge.
    task automatic send(input logic [V-1:0] a, input logic [V-1:0] b,
                        input logic [2:0] sew, input logic [1:0] op,
                        input logic [TW-1:0] tag, input logic [V-1:0] er,
                        input logic ee, input bit lat);
        int   n;
        exp_t e;
        n = 0;
        a_i = a; b_i = b; sew_i = sew; op_i = op; tag_i = tag;
        valid_i = 1'b1;
        #1;
        while (!ready_o && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: tag %h not accepted", tag);
            @(negedge clk);
            valid_i = 1'b0;
            return;
        end
        e.res = er; e.tag = tag; e.err = ee; e.lat = lat; e.acc = cyc + 1;
        @(posedge clk);
        q.push_back(e);
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding", q.size());
            q.delete();
        end
    endtask

    initial begin : monitor
        exp_t          e;
        bit            stall;
        logic [V-1:0]  hres;
        logic [TW-1:0] htag;
        stall = 0;
        hres  = '0;
        htag  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_ni) begin
                stall = 0;
                continue;
            end
            check("ready_o", V'(ready_o), V'(ready_i || q.size() < S));
            if (stall) begin
                check("hold_valid", V'(valid_o), V'(1));
                check("hold_res", res_o, hres);
                check("hold_tag", V'(tag_o), V'(htag));
            end
            stall = valid_o && !ready_i;
            hres  = res_o;
            htag  = tag_o;
            if (valid_o && ready_i) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected: tag %h res %h", tag_o, res_o);
                end else begin
                    e = q.pop_front();
                    check("res", res_o, e.res);
                    check("tag", V'(tag_o), V'(e.tag));
                    check("err", V'(err_o), V'(e.err));
                    if (e.lat) check("latency", V'(cyc - e.acc), V'(S - 1));
                end
            end
        end
    end

    logic [V-1:0] ones;
    logic [V-1:0] a32;
    logic [V-1:0] b32;

    initial begin
        ones = '1;
        a32  = {8{32'h8000_0000}};
        b32  = {8{32'h0000_0002}};

        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", V'(valid_o), '0);
        check("rst_err", V'(err_o), '0);
        check("rst_res", res_o, '0);
        check("rst_tag", V'(tag_o), '0);
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        check("rst_ready", V'(ready_o), V'(1));
        @(negedge clk);

        send({32{8'hFF}}, {32{8'h02}}, 3'b000, 2'b00, 8'h01,
             {32{8'hFE}}, 1'b0, 1'b1);
        wait_drain();

        send(ones, ones, 3'b001, 2'b01, 8'h10, '0, 1'b0, 1'b0);
        send(ones, ones, 3'b001, 2'b10, 8'h11, {16{16'hFFFE}}, 1'b0, 1'b0);
        send(ones, ones, 3'b001, 2'b11, 8'h12, {16{16'hFFFF}}, 1'b0, 1'b0);
        send(ones, ones, 3'b001, 2'b00, 8'h13, {16{16'h0001}}, 1'b0, 1'b0);
        send(ones, ones, 3'b011, 2'b10, 8'h20,
             {4{64'hFFFF_FFFF_FFFF_FFFE}}, 1'b0, 1'b0);
        send(ones, ones, 3'b011, 2'b00, 8'h21,
             {4{64'h0000_0000_0000_0001}}, 1'b0, 1'b0);
        send(a32, b32, 3'b010, 2'b01, 8'h30, {8{32'hFFFF_FFFF}}, 1'b0, 1'b0);
        send(a32, b32, 3'b010, 2'b10, 8'h31, {8{32'h0000_0001}}, 1'b0, 1'b0);
        send(a32, b32, 3'b010, 2'b11, 8'h32, {8{32'hFFFF_FFFF}}, 1'b0, 1'b0);
        send(a32, b32, 3'b010, 2'b00, 8'h33, '0, 1'b0, 1'b0);
        wait_drain();

        fork
            for (int i = 0; i < 10; i++) begin
                logic [7:0] av;
                logic [7:0] rv;
                av = 8'(i + 1);
                rv = 8'(3 * (i + 1));
                send({32{av}}, {32{8'h03}}, 3'b000, 2'b00, 8'(i),
                     {32{rv}}, 1'b0, 1'b0);
            end
            begin
                repeat (4) @(negedge clk);
                ready_i = 1'b0;
                repeat (5) @(negedge clk);
                ready_i = 1'b1;
            end
        join
        wait_drain();

        send(ones, ones, 3'b100, 2'b00, 8'h5A, '0, 1'b1, 1'b0);
        send(ones, ones, 3'b001, 2'b00, 8'h5B, {16{16'h0001}}, 1'b0, 1'b0);
        wait_drain();

        ready_i = 1'b0;
        send(ones, ones, 3'b001, 2'b00, 8'hE0, '0, 1'b0, 1'b0);
        send(ones, ones, 3'b001, 2'b00, 8'hE1, '0, 1'b0, 1'b0);
        send(ones, ones, 3'b001, 2'b00, 8'hE2, '0, 1'b0, 1'b0);
        #3;
        rst_ni = 1'b0;
        #1;
        check("midrst_valid", V'(valid_o), '0);
        q.delete();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        #1;
        check("midrst_ready", V'(ready_o), V'(1));
        check("midrst_tag", V'(tag_o), '0);
        ready_i = 1'b1;
        repeat (10) @(negedge clk);

        send({32{8'h07}}, {32{8'h05}}, 3'b000, 2'b00, 8'h77,
             {32{8'h23}}, 1'b0, 1'b0);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
